// File: rtl/booth_pkg.sv
// Shared types for the Booth multiply scheduler: FSM states, Booth op codes and helpers.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Requester index width; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic shift right of {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    booth_op_e      op;

    assign m_ext = {m_i[WIDTH-1], m_i};
    assign op    = booth_decode(q_i[0], q1_i);

    always_comb begin
        case (op)
            OP_ADD:  sum = a_i + m_ext;
            OP_SUB:  sum = a_i - m_ext;
            default: sum = a_i;
        endcase
    end

    assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o  = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o = q_i[0];

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one iterative Booth multiplier among N_REQ requesters.
// Optional BOOTH_SCHED_PERF_EN adds perf_ops_o, a saturating count of response handshakes.
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter int   N_REQ = 4,
    parameter int   WIDTH = 4,
    localparam int  IDW   = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*WIDTH-1:0] req_m_i,
    input  logic [N_REQ*WIDTH-1:0] req_q_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [2*WIDTH-1:0]     rsp_product_o,
    output logic                   busy_o
`ifdef BOOTH_SCHED_PERF_EN
    ,
    output logic [15:0]            perf_ops_o
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] qr_q;
    logic             q1_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             req_hs;
    logic [WIDTH-1:0] sel_m, sel_q;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q1_nxt;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % N_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign ptr_d  = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);
    assign req_hs = (state_q == ST_IDLE) && grant_found;
    assign sel_m  = req_m_i[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_q  = req_q_i[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (req_hs) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i  (a_q),
        .q_i  (qr_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (a_nxt),
        .q_o  (q_nxt),
        .q1_o (q1_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            m_q         <= '0;
            a_q         <= '0;
            qr_q        <= '0;
            q1_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        m_q     <= sel_m;
                        a_q     <= '0;
                        qr_q    <= sel_q;
                        q1_q    <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        id_q    <= grant_idx;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    a_q   <= a_nxt;
                    qr_q  <= q_nxt;
                    q1_q  <= q1_nxt;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = id_q;
    assign rsp_product_o = {a_q[WIDTH-1:0], qr_q};
    assign busy_o        = busy_q;

`ifdef BOOTH_SCHED_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (rsp_valid_q && rsp_ready_i && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_ops_o = perf_q;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: grants are predicted by a round-robin model, products
// by signed integer multiplication, and a separate monitor checks each response as it appears.
module tb_booth_mul_sched;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;
    localparam int NW  = N * W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid_i = '0;
    logic [N-1:0]     req_ready_o;
    logic [NW-1:0]    req_m_i = '0;
    logic [NW-1:0]    req_q_i = '0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b1;
    logic [IDW-1:0]   rsp_id_o;
    logic [2*W-1:0]   rsp_product_o;
    logic             busy_o;
`ifdef BOOTH_SCHED_PERF_EN
    logic [15:0]      perf_ops;
`endif

    booth_mul_sched #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_m_i       (req_m_i),
        .req_q_i       (req_q_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_product_o (rsp_product_o),
        .busy_o        (busy_o)
`ifdef BOOTH_SCHED_PERF_EN
        ,
        .perf_ops_o    (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             t;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_fail = 0;
    int rr_ptr = 0;
    int n_push = 0;
    int n_hs_since_rst = 0;

    logic [N-1:0]  nxt_valid = '0;
    logic [NW-1:0] nxt_m = '0;
    logic [NW-1:0] nxt_q = '0;
    logic          nxt_rdy = 1'b1;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        int           w;
        int           p;
        logic [N-1:0] oh;
        logic [W-1:0] mv, qv;
        exp_t         e;
        @(negedge clk);
        req_valid_i = nxt_valid;
        req_m_i     = nxt_m;
        req_q_i     = nxt_q;
        rsp_ready_i = nxt_rdy;
        #1;
        if (rst_n && (req_ready_o != '0)) begin
            w  = model_pick(req_valid_i, rr_ptr);
            oh = '0;
            if (w >= 0) oh[w] = 1'b1;
            check("grant_onehot", int'(req_ready_o), int'(oh));
            if (w >= 0 && req_ready_o == oh) begin
                mv     = req_m_i[w*W +: W];
                qv     = req_q_i[w*W +: W];
                p      = $signed(mv) * $signed(qv);
                e.id   = w;
                e.prod = p[2*W-1:0];
                e.t    = cyc;
                sb.push_back(e);
                rr_ptr = (w + 1) % N;
                n_push++;
            end
        end
    endtask

    task automatic issue(input int id, input logic [W-1:0] m, input logic [W-1:0] q);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        nxt_valid = '0;
        nxt_valid[id] = 1'b1;
        nxt_m[id*W +: W] = m;
        nxt_q[id*W +: W] = q;
        while (!got && n < 50) begin
            step();
            got = (req_valid_i & req_ready_o) != '0;
            n++;
        end
        check("issue_granted", int'(got), 1);
        nxt_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        nxt_valid = '0;
        nxt_rdy   = 1'b1;
        while ((sb.size() > 0 || busy_o) && n < 100) begin
            step();
            n++;
        end
        check("drain_queue_empty", sb.size(), 0);
        check("drain_busy_low", int'(busy_o), 0);
    endtask

    // Monitor: compares each presented response against the head of the scoreboard.
    initial begin
        exp_t cur;
        bit   have;
        have = 1'b0;
        cur.id = 0;
        cur.prod = '0;
        cur.t = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                have = 1'b0;
            end else if (rsp_valid_o) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got id %0d product 0x%0h, expected none",
                                 rsp_id_o, rsp_product_o);
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                        check("rsp_latency", cyc - cur.t, W + 1);
                    end
                end
                if (have) begin
                    check("rsp_id", int'(rsp_id_o), cur.id);
                    check("rsp_product", int'(rsp_product_o), int'(cur.prod));
                    check("busy_in_done", int'(busy_o), 1);
                    check("no_grant_in_done", int'(req_ready_o), 0);
                    if (rsp_ready_i) begin
                        have = 1'b0;
                        n_hs_since_rst++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int start;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rsp_valid", int'(rsp_valid_o), 0);
        check("reset_req_ready", int'(req_ready_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_rsp_id", int'(rsp_id_o), 0);
        check("reset_rsp_product", int'(rsp_product_o), 0);
        rst_n = 1'b1;

        // Corner operands, one requester at a time.
        issue(0, 4'd3, 4'b1110);
        drain();
        issue(1, 4'b1000, 4'b1000);
        issue(2, 4'b1000, 4'd7);
        issue(3, 4'd0, 4'hF);
        drain();

        // All requesters held valid: rotation 0,1,2,3,0.
        start = n_push;
        nxt_valid = '1;
        n = 0;
        while ((n_push - start) < 5 && n < 100) begin
            nxt_m = NW'($urandom);
            nxt_q = NW'($urandom);
            step();
            n++;
        end
        check("rotation_grants", n_push - start, 5);
        drain();

        // Consumer stalls with the product held in the done state.
        issue(2, 4'(($urandom)), 4'(($urandom)));
        nxt_rdy = 1'b0;
        repeat (16) step();
        check("stall_rsp_held", int'(rsp_valid_o), 1);
        check("stall_busy", int'(busy_o), 1);
        drain();

        // Random traffic with backpressure.
        repeat (400) begin
            nxt_valid = N'($urandom);
            nxt_m     = NW'($urandom);
            nxt_q     = NW'($urandom);
            nxt_rdy   = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset in the middle of an iteration discards the operation.
        issue(1, 4'd5, 4'd6);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", int'(rsp_valid_o), 0);
        check("midreset_busy", int'(busy_o), 0);
        check("midreset_req_ready", int'(req_ready_o), 0);
        check("midreset_rsp_product", int'(rsp_product_o), 0);
        sb.delete();
        rr_ptr = 0;
        n_hs_since_rst = 0;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("midreset_no_rsp", int'(rsp_valid_o), 0);
        nxt_valid = '1;
        nxt_m = NW'($urandom);
        nxt_q = NW'($urandom);
        step();
        check("post_reset_grant", int'(req_ready_o), 1);
        nxt_valid = '0;
        drain();

`ifdef BOOTH_SCHED_PERF_EN
        check("perf_ops", int'(perf_ops), n_hs_since_rst);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
